// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, accelerator) arbiter in front of the single-port data memory.
// Optional DMEM_ARB_PERF_EN adds saturating grant and stall counters.
module dmem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_uns,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [1:0]        acc_size,
  input  logic              acc_uns,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic              acc_err,
  output logic [31:0]       acc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_cpu_cnt,
  output logic [15:0]       perf_acc_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  // Handshake: req is held with stable fields until gnt; gnt and req high in the
  // same cycle transfer the access. Exactly one rvalid pulse answers each grant.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic        last_win_q;  // 1 = accelerator won last
  logic        own_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [2:0]  cnt_q;

  logic              grant, win_acc, sel_we, sel_uns, sel_err;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata, raw, ext;

  function automatic logic is_err(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    win_acc   = acc_req && (!cpu_req || !last_win_q);
    grant     = reset && (state_q == IDLE) && (cpu_req || acc_req);
    cpu_gnt   = grant && !win_acc;
    acc_gnt   = grant && win_acc;
    sel_we    = win_acc ? acc_we    : cpu_we;
    sel_size  = win_acc ? acc_size  : cpu_size;
    sel_uns   = win_acc ? acc_uns   : cpu_uns;
    sel_addr  = win_acc ? acc_addr  : cpu_addr;
    sel_wdata = win_acc ? acc_wdata : cpu_wdata;
    sel_err   = is_err(sel_size, sel_addr[1:0]);
  end

  // Lane extraction of the returned word for the captured access.
  always_comb begin
    raw = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   ext = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = sel_err ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_win_q <= 1'b1;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      cnt_q      <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'b0;
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'b0;
      acc_rvalid <= 1'b0;
      acc_err    <= 1'b0;
      acc_rdata  <= 32'b0;
    end else begin
      state_q    <= state_d;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'b0;
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'b0;
      acc_rvalid <= 1'b0;
      acc_err    <= 1'b0;
      acc_rdata  <= 32'b0;
      if (grant) begin
        last_win_q <= win_acc;
        own_q      <= win_acc;
        we_q       <= sel_we;
        size_q     <= sel_size;
        uns_q      <= sel_uns;
        lane_q     <= sel_addr[1:0];
        if (sel_err) begin
          cpu_rvalid <= !win_acc;
          cpu_err    <= !win_acc;
          acc_rvalid <= win_acc;
          acc_err    <= win_acc;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= sel_we;
          mem_be    <= lane_be(sel_size, sel_addr[1:0]);
          mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
          mem_wdata <= sel_wdata << {sel_addr[1:0], 3'b000};
        end
      end
      if (state_q == ISSUE) cnt_q <= LAT_M1;
      if (state_q == WAIT) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          cpu_rvalid <= !own_q;
          acc_rvalid <= own_q;
          if (!own_q) cpu_rdata <= we_q ? 32'b0 : ext;
          else        acc_rdata <= we_q ? 32'b0 : ext;
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cpu_cnt   <= 16'd0;
      perf_acc_cnt   <= 16'd0;
      perf_stall_cnt <= 16'd0;
    end else begin
      if (cpu_gnt && perf_cpu_cnt != 16'hFFFF) perf_cpu_cnt <= perf_cpu_cnt + 16'd1;
      if (acc_gnt && perf_acc_cnt != 16'hFFFF) perf_acc_cnt <= perf_acc_cnt + 16'd1;
      if ((cpu_req || acc_req) && !grant && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table on a MEM_LAT=1 instance plus hand sequences
// (round-robin, reset in WAIT, MEM_LAT=3 sampling point).
module tb_dmem_arbiter;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, cpu_uns = 0;
  logic [1:0]  cpu_size = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        acc_req = 0, acc_we = 0, acc_uns = 0;
  logic [1:0]  acc_size = 0;
  logic [31:0] acc_addr = 0, acc_wdata = 0;
  logic [31:0] mem_rdata = 0;
  logic        cpu_gnt, cpu_rvalid, cpu_err, acc_gnt, acc_rvalid, acc_err;
  logic [31:0] cpu_rdata, acc_rdata, mem_addr, mem_wdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  logic        z_cpu_req = 0;
  logic [31:0] z_cpu_addr = 0, z_mem_rdata = 0;
  logic        z_cpu_gnt, z_cpu_rvalid, z_cpu_err, z_acc_gnt, z_acc_rvalid, z_acc_err;
  logic [31:0] z_cpu_rdata, z_acc_rdata, z_mem_addr, z_mem_wdata;
  logic        z_mem_en, z_mem_we;
  logic [3:0]  z_mem_be;
  logic [1:0]  z_dbg_state;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] p_cpu, p_acc, p_stall, zp_cpu, zp_acc, zp_stall;
`endif

  dmem_arbiter #(.MEM_LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_uns(cpu_uns),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_size(acc_size), .acc_uns(acc_uns),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .acc_err(acc_err), .acc_rdata(acc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_cnt(p_cpu), .perf_acc_cnt(p_acc), .perf_stall_cnt(p_stall)
`endif
  );

  dmem_arbiter #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_we(1'b0), .cpu_size(2'b10), .cpu_uns(1'b0),
    .cpu_addr(z_cpu_addr), .cpu_wdata(32'h0), .cpu_gnt(z_cpu_gnt), .cpu_rvalid(z_cpu_rvalid),
    .cpu_err(z_cpu_err), .cpu_rdata(z_cpu_rdata),
    .acc_req(1'b0), .acc_we(1'b0), .acc_size(2'b00), .acc_uns(1'b0),
    .acc_addr(32'h0), .acc_wdata(32'h0), .acc_gnt(z_acc_gnt), .acc_rvalid(z_acc_rvalid),
    .acc_err(z_acc_err), .acc_rdata(z_acc_rdata),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .dbg_state(z_dbg_state)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_cnt(zp_cpu), .perf_acc_cnt(zp_acc), .perf_stall_cnt(zp_stall)
`endif
  );

  typedef struct {
    logic        who;    // 0 cpu, 1 acc
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    if (v.who) begin
      acc_req = 1; acc_we = v.we; acc_size = v.size; acc_uns = v.uns;
      acc_addr = v.addr; acc_wdata = v.wdata;
    end else begin
      cpu_req = 1; cpu_we = v.we; cpu_size = v.size; cpu_uns = v.uns;
      cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, t_rv, t_en, n_en;
    logic oth, g_err, g_we;
    logic [3:0] g_be;
    logic [31:0] g_addr, g_wd, g_rd, e_rd;
    string tag;
    tag = $sformatf("v%0d", idx);
    exp_q.push_back(v.rdata);
    @(negedge clk);
    drive_req(v);
    k = 0;
    #1;
    while (!(v.who ? acc_gnt : cpu_gnt) && k < 10) begin
      @(negedge clk); #1; k++;
    end
    check({tag, "_gnt"}, {31'b0, v.who ? acc_gnt : cpu_gnt}, 32'd1);
    t_rv = 0; t_en = 0; n_en = 0; oth = 0;
    g_err = 0; g_we = 0; g_be = 0; g_addr = 0; g_wd = 0; g_rd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin cpu_req = 0; acc_req = 0; end
      mem_rdata = (c == LAT + 1) ? v.mrd : ~v.mrd;
      #1;
      if (mem_en) begin
        n_en++; t_en = c; g_be = mem_be; g_addr = mem_addr; g_wd = mem_wdata; g_we = mem_we;
      end
      if ((v.who ? acc_rvalid : cpu_rvalid) && t_rv == 0) begin
        t_rv = c;
        g_err = v.who ? acc_err : cpu_err;
        g_rd = v.who ? acc_rdata : cpu_rdata;
      end
      if (v.who ? cpu_rvalid : acc_rvalid) oth = 1;
    end
    check({tag, "_rv_cycle"}, t_rv, v.err ? 32'd1 : 32'(LAT + 2));
    check({tag, "_mem_en_cnt"}, n_en, v.err ? 32'd0 : 32'd1);
    if (!v.err) begin
      check({tag, "_mem_en_cycle"}, t_en, 32'd1);
      check({tag, "_mem_be"}, {28'b0, g_be}, {28'b0, v.be});
      check({tag, "_mem_addr"}, g_addr, v.maddr);
      check({tag, "_mem_wdata"}, g_wd, v.mwdata);
      check({tag, "_mem_we"}, {31'b0, g_we}, {31'b0, v.we});
    end
    check({tag, "_err"}, {31'b0, g_err}, {31'b0, v.err});
    e_rd = exp_q.pop_front();
    check({tag, "_rdata"}, g_rd, e_rd);
    check({tag, "_other_rvalid"}, {31'b0, oth}, 32'd0);
  endtask

  initial begin
    int g_who[4];
    int g_cyc[4];
    int ng, t_rv, t_en;
    logic seen;
    logic [31:0] g_rd;

    //          who   we    size   uns   addr          wdata         mrd           be       maddr         mwdata        err   rdata
    vecs[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h00000013, 32'h00000000, 32'h80FF0000, 4'b1000, 32'h00000010, 32'h00000000, 1'b0, 32'hFFFFFF80};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h00000013, 32'h00000000, 32'h80FF0000, 4'b1000, 32'h00000010, 32'h00000000, 1'b0, 32'h00000080};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 1'b0, 32'h00000022, 32'h0000BEEF, 32'h12345678, 4'b1100, 32'h00000020, 32'hBEEF0000, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h00000000, 32'h12345678, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h00000008, 32'h00000000, 32'h12345678, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h00000001, 32'h00000000, 32'h12345678, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
    vecs[6]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000000, 32'hCAFEF00D, 4'b1111, 32'h00000100, 32'h00000000, 1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h00000002, 32'h00000000, 32'h80011234, 4'b1100, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFF8001};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h00000000, 32'h00000000, 32'h80019234, 4'b0011, 32'h00000000, 32'h00000000, 1'b0, 32'h00009234};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h00000001, 32'h000000A5, 32'h12345678, 4'b0010, 32'h00000000, 32'h0000A500, 1'b0, 32'h00000000};
    vecs[10] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h00000044, 32'h11223344, 32'h12345678, 4'b1111, 32'h00000044, 32'h11223344, 1'b0, 32'h00000000};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h00000004, 32'h00000000, 32'h000000FF, 4'b0001, 32'h00000004, 32'h00000000, 1'b0, 32'hFFFFFFFF};

    // Reset state
    #12;
    check("reset_outs", {mem_en, mem_we, mem_be, cpu_rvalid, cpu_err, acc_rvalid, acc_err, dbg_state},
          32'd0);
    check("reset_data", mem_addr | mem_wdata | cpu_rdata | acc_rdata, 32'd0);
    @(negedge clk);
    reset = 1;

    // Both requesters held: grants alternate, CPU first after reset
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_size = 2'b10; cpu_addr = 0;
    acc_req = 1; acc_we = 0; acc_size = 2'b10; acc_addr = 0;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (cpu_gnt || acc_gnt) begin
        g_who[ng] = acc_gnt ? 1 : 0; g_cyc[ng] = c; ng++;
      end
      @(negedge clk);
    end
    cpu_req = 0; acc_req = 0;
    check("rr_grant_count", ng, 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) begin
      check($sformatf("rr_who%0d", i), g_who[i], (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) check($sformatf("rr_gap%0d", i), g_cyc[i] - g_cyc[i-1], 32'(LAT + 3));
    end
    repeat (6) @(negedge clk);

    // Vector table
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset while an ACC load is in WAIT
    @(negedge clk);
    acc_req = 1; acc_we = 0; acc_size = 2'b10; acc_uns = 0; acc_addr = 32'h8;
    ng = 0;
    #1;
    while (!acc_gnt && ng < 10) begin @(negedge clk); #1; ng++; end
    check("rstw_gnt", {31'b0, acc_gnt}, 32'd1);
    @(negedge clk); acc_req = 0;
    @(negedge clk); #1;
    check("rstw_in_wait", {30'b0, dbg_state}, 32'd2);
    reset = 0;
    #1;
    check("rstw_outs", {mem_en, mem_we, mem_be, cpu_rvalid, cpu_err, acc_rvalid, acc_err, dbg_state},
          32'd0);
    check("rstw_data", mem_addr | mem_wdata | cpu_rdata | acc_rdata, 32'd0);
    seen = 0;
    repeat (2) begin @(negedge clk); #1; if (acc_rvalid) seen = 1; end
    reset = 1;
    repeat (4) begin @(negedge clk); #1; if (acc_rvalid) seen = 1; end
    check("rstw_no_rvalid", {31'b0, seen}, 32'd0);
    @(negedge clk);
    cpu_req = 1; cpu_size = 2'b10; cpu_addr = 0;
    acc_req = 1;
    #1;
    check("rstw_cpu_first", {30'b0, cpu_gnt, acc_gnt}, 32'd2);
    @(negedge clk);
    cpu_req = 0; acc_req = 0;
    repeat (6) @(negedge clk);

    // MEM_LAT = 3: data valid only in T+4, rvalid at T+5
    z_cpu_req = 1; z_cpu_addr = 32'h40;
    ng = 0;
    #1;
    while (!z_cpu_gnt && ng < 10) begin @(negedge clk); #1; ng++; end
    check("lat3_gnt", {31'b0, z_cpu_gnt}, 32'd1);
    t_rv = 0; t_en = 0; g_rd = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) z_cpu_req = 0;
      z_mem_rdata = (c == 4) ? 32'h5A5A5A5A : 32'hA5A5A5A5;
      #1;
      if (z_mem_en) t_en = c;
      if (z_cpu_rvalid && t_rv == 0) begin t_rv = c; g_rd = z_cpu_rdata; end
    end
    check("lat3_mem_en_cycle", t_en, 32'd1);
    check("lat3_rv_cycle", t_rv, 32'd5);
    check("lat3_rdata", g_rd, 32'h5A5A5A5A);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store path (requester 0) and the motor-control accelerator (requester 1).
- Arbitrates between the two, serialises accesses, and checks alignment.
- Generates byte enables, then returns lane-extracted, sign- or zero-extended load data or a write acknowledge.
- Sits between the CPU and accelerator and the `dmem` block.

Parameters:
- MEM_LAT, 1: cycles from the mem_en cycle to mem_rdata valid; legal range 1..7.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = store, 0 = load
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_uns  in  1  load zero-extend when 1, sign-extend when 0
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data, right-justified
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  one-cycle response strobe
- cpu_err  out  1  misaligned or illegal access; valid with cpu_rvalid
- cpu_rdata  out  32  load result; 0 for stores and errors
- acc_req, acc_we, acc_size, acc_uns, acc_addr, acc_wdata, acc_gnt, acc_rvalid, acc_err, acc_rdata: same as the cpu_ set, for the accelerator
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_be  out  4  byte lane enables
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-shifted write data
- mem_rdata  in  32  read word

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; last_win = ACC.
  - All outputs are 0.
  - Any in-flight access is dropped with no rvalid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Only one requester active: that requester wins.
  - Both active: the requester that is not last_win wins (round-robin), so CPU wins the first tie after reset.
  - Winner's gnt is high for exactly one cycle (T). All request fields are captured into registers at the end of T, and last_win is updated.
- Transitions:
  - Legal access: IDLE → ISSUE.
  - Error access: IDLE → RESP, with err = 1 and no memory access.
- Error conditions:
  - size = 11.
  - Half with addr[0] = 1.
  - Word with addr[1:0] ≠ 0.
- ISSUE (cycle T+1):
  - mem_en = 1 for one cycle; mem_we = captured we.
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - mem_be: byte = 0001 << addr[1:0]; half = 0011 << addr[1:0]; word = 1111.
  - mem_wdata = wdata << (8 × addr[1:0]).
- WAIT: counts MEM_LAT cycles. mem_rdata is sampled at the end of cycle T+1+MEM_LAT and lane-extracted:
  - raw = mem_rdata >> (8 × addr[1:0]).
  - Byte and half results are extended per uns; word results are passed unmodified.
- RESP (cycle T+2+MEM_LAT):
  - The owning requester's rvalid = 1 for one cycle, with rdata and err.
  - The other requester's rvalid stays 0.
  - Stores return rdata = 0 and err = 0.
  - Error responses occur at T+1, with rdata = 0.
  - Next state is always IDLE.
- Throughput: one outstanding access at most. No gnt is issued outside IDLE; requests arriving in other states wait.
- Request handling:
  - A requester may drop req after gnt without effect.
  - A req deasserted before gnt is simply not served.
- All outputs are registered except gnt, which is a combinational function of state, req and last_win.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_cpu_cnt [15:0], perf_acc_cnt [15:0] and perf_stall_cnt [15:0].
  - perf_cpu_cnt and perf_acc_cnt count grants per requester.
  - perf_stall_cnt counts cycles in which any req is high and no gnt is given.
  - All counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: the ports and logic are absent; remaining behaviour is identical.

Test Plan:
- CPU lb, addr 0x00000013, mem_rdata 0x80FF_0000, MEM_LAT 1:
  - cpu_gnt at T; mem_en at T+1 with mem_be 1000 and mem_addr 0x10.
  - cpu_rvalid at T+3 with rdata 0xFFFF_FF80 and err 0; with cpu_uns = 1, rdata 0x0000_0080.
- ACC sh, addr 0x22, wdata 0x0000_BEEF:
  - mem_we 1, mem_be 1100, mem_wdata 0xBEEF_0000.
  - acc_rvalid with rdata 0.
- cpu_req and acc_req both held high continuously:
  - Grants alternate CPU, ACC, CPU, ACC.
  - Each grant is separated by MEM_LAT + 3 cycles.
- CPU lw at addr 0x6:
  - No mem_en.
  - cpu_rvalid at T+1 with err 1 and rdata 0.
  - Same error response for size = 11.
- reset asserted in WAIT after an ACC load:
  - All outputs go to 0 immediately; acc_rvalid is never asserted.
  - After release, a simultaneous request is granted to CPU first.
- MEM_LAT = 3: rvalid at T+5; data is sampled exactly at T+4.
